// File: rtl/mem_block_reader.sv
// rtl/mem_block_reader.sv - sequential block read engine: memory words to a valid/ready stream
// Optional running XOR checksum of delivered words when MEM_RD_CHECKSUM_EN is defined.
module mem_block_reader #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_enable,
    output logic              mem_R_W,
    output logic [ADDR_W-1:0] mem_Address,
    input  logic [DATA_W-1:0] mem_D_Out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_OUT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [WAIT_W-1:0] wait_q;
    logic              wait_done;
    logic              last_word;
    logic              accept_start;
    logic              handshake;

    assign wait_done    = (wait_q == WAIT_W'(RD_WAIT - 1));
    assign last_word    = (remaining_q == LEN_W'(1));
    assign accept_start = (state == S_IDLE) && start;
    assign handshake    = (state == S_OUT) && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        mem_enable = (state == S_ADDR);
        out_valid  = (state == S_OUT);
        case (state)
            S_IDLE: if (start) state_nxt = (length == '0) ? S_DONE : S_ADDR;
            S_ADDR: if (wait_done) state_nxt = S_OUT;
            S_OUT:  if (out_ready) state_nxt = last_word ? S_DONE : S_ADDR;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address and remaining count only advance on a handshake that is not the final word,
    // so mem_Address keeps pointing at the last word read once the transfer ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            if (accept_start) begin
                addr_q      <= base_addr;
                remaining_q <= length;
                wait_q      <= '0;
            end else if (state == S_ADDR) begin
                if (wait_done) begin
                    out_data <= mem_D_Out;
                    out_last <= last_word;
                    wait_q   <= '0;
                end else begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
            end else if (handshake && !last_word) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    assign mem_Address = addr_q;
    assign mem_R_W     = 1'b1;

`ifdef MEM_RD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if (accept_start) begin
            checksum_q <= '0;
        end else if (handshake) begin
            checksum_q <= checksum_q ^ out_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_block_reader.sv
// tb/tb_mem_block_reader.sv - self-checking bench for mem_block_reader against a queue-based reference
module tb_mem_block_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy, done, mem_enable, mem_R_W;
    logic [15:0] mem_Address;
    logic [31:0] mem_D_Out;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data, checksum;

    logic [31:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [15:0] got_addr[$];
    int          last_hs, done_edge, stall_cnt, valid_cycles;
    logic [31:0] cks_at_done;

    always #5 clk = ~clk;

    assign mem_D_Out = mem_enable ? mem[mem_Address] : 32'hDEAD_BEEF;

    mem_block_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_enable(mem_enable), .mem_R_W(mem_R_W),
        .mem_Address(mem_Address), .mem_D_Out(mem_D_Out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .checksum(checksum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".mem_enable"}, 32'(mem_enable), 32'd0);
        chk({tag, ".mem_R_W"}, 32'(mem_R_W), 32'd1);
        chk({tag, ".mem_Address"}, 32'(mem_Address), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_data"}, out_data, 32'd0);
        chk({tag, ".out_last"}, 32'(out_last), 32'd0);
        chk({tag, ".checksum"}, checksum, 32'd0);
    endtask

    // mode 0: ready always high; mode 1: random ready; mode 2: 3-cycle stall on word 000000BB
    task automatic do_xfer(input logic [15:0] b, input logic [15:0] n, input int mode, input string tag);
        bit          pv, pr, pme, finished;
        logic [31:0] pd;
        logic [15:0] la;
        got_data.delete(); got_last.delete(); got_addr.delete();
        last_hs = -1; done_edge = -1; stall_cnt = 0; valid_cycles = 0; cks_at_done = 'x;
        pv = 0; pr = 1; pme = 0; la = '0; pd = '0; finished = 0;
        @(negedge clk);
        base_addr = b; length = n; start = 1'b1;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < 4000 && !finished; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
            if (pv && !pr) begin
                chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, ".hold_data"}, out_data, pd);
            end
            if (mem_enable && (!pme || mem_Address != la)) got_addr.push_back(mem_Address);
            pme = mem_enable; la = mem_Address;
            if (out_valid) valid_cycles++;
            if (done_edge >= 0) begin
                chk({tag, ".busy_after_done"}, 32'(busy), 32'd0);
                chk({tag, ".done_width"}, 32'(done), 32'd0);
                finished = 1;
            end else if (done) begin
                done_edge = k;
                cks_at_done = checksum;
                chk({tag, ".busy_at_done"}, 32'(busy), 32'd1);
            end
            start = 1'b0;
            base_addr = 16'($urandom);
            length = 16'($urandom);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid && out_data == 32'h0000_00BB && stall_cnt < 3) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                        chk({tag, ".stall_mem_enable"}, 32'(mem_enable), 32'd0);
                        start = (stall_cnt == 2);
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                last_hs = k + 1;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
        end
        chk({tag, ".completed"}, 32'(finished), 32'd1);
    endtask

    task automatic check_xfer(input logic [15:0] b, input logic [15:0] n, input int mode, input string tag);
        logic [31:0] model_xor;
        logic [15:0] a;
        model_xor = '0;
        chk({tag, ".word_count"}, 32'(got_data.size()), 32'(n));
        chk({tag, ".addr_count"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < int'(n); i++) begin
            a = b + 16'(i);
            model_xor ^= mem[a];
            if (i < got_data.size()) begin
                chk($sformatf("%s.data[%0d]", tag, i), got_data[i], mem[a]);
                chk($sformatf("%s.last[%0d]", tag, i), 32'(got_last[i]), 32'(i == int'(n) - 1));
            end
            if (i < got_addr.size()) chk($sformatf("%s.addr[%0d]", tag, i), 32'(got_addr[i]), 32'(a));
        end
        if (n == 0) chk({tag, ".valid_cycles"}, 32'(valid_cycles), 32'd0);
        if (mode == 0) begin
            if (n != 0) chk({tag, ".last_hs_cycle"}, 32'(last_hs), 32'(2 * int'(n)));
            chk({tag, ".done_cycle"}, 32'(done_edge), 32'(2 * int'(n)));
        end
`ifdef MEM_RD_CHECKSUM_EN
        chk({tag, ".checksum"}, cks_at_done, model_xor);
`else
        chk({tag, ".checksum"}, cks_at_done, 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] rb, rn;
        int          hs, mode;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_AAAA; mem[1] = 32'h0000_00AA; mem[2] = 32'h0000_00BB; mem[3] = 32'h0000_00CC;
        mem[4] = 32'h0000_00DD; mem[5] = 32'h0000_00EE; mem[6] = 32'h0000_00FF; mem[7] = 32'h0000_FFFF;

        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; length = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;

        do_xfer(16'h0000, 16'd8, 0, "s1");
        check_xfer(16'h0000, 16'd8, 0, "s1");
`ifdef MEM_RD_CHECKSUM_EN
        chk("s1.checksum_const", cks_at_done, 32'h0000_5544);
`endif

        do_xfer(16'h0000, 16'd8, 2, "s2");
        check_xfer(16'h0000, 16'd8, 2, "s2");
        chk("s2.stall_cycles", 32'(stall_cnt), 32'd3);

        do_xfer(16'h1234, 16'd0, 0, "s3");
        check_xfer(16'h1234, 16'd0, 0, "s3");

        do_xfer(16'hFFFE, 16'd4, 0, "s4");
        check_xfer(16'hFFFE, 16'd4, 0, "s4");

        @(negedge clk);
        base_addr = 16'h0000; length = 16'd8; start = 1'b1; out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 100 && hs < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_ready) hs++;
        end
        @(negedge clk);
        chk("s5.pre_reset_enable", 32'(mem_enable), 32'd1);
        #1 reset_n = 1'b0;
        #1 chk_reset("s5.async");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s5.held_enable", 32'(mem_enable), 32'd0);
        end
        reset_n = 1'b1;
        do_xfer(16'h0000, 16'd2, 0, "s6");
        check_xfer(16'h0000, 16'd2, 0, "s6");
        if (got_data.size() == 2) begin
            chk("s6.word0", got_data[0], 32'h0000_AAAA);
            chk("s6.word1", got_data[1], 32'h0000_00AA);
        end

        for (int t = 0; t < 8; t++) begin
            rb = (t % 2 == 0) ? 16'($urandom) : 16'hFFF8 + 16'($urandom_range(0, 7));
            rn = 16'($urandom_range(1, 12));
            mode = $urandom_range(0, 1);
            do_xfer(rb, rn, mode, $sformatf("rnd%0d", t));
            check_xfer(rb, rn, mode, $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_block_reader.md
# mem_block_reader

Sequential read engine for the 16-bit-address / 32-bit-data `memory` block. On `start` it reads `length` consecutive words beginning at `base_addr` and delivers them on a valid/ready output stream, one word per handshake. It is the read-side counterpart to the existing memory write path. It sits between the memory and any consumer (dump logic, DMA, checker) and is the only master driving the memory's read controls while busy.

## Interface
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 32, memory data width.
- `LEN_W`, 16, transfer length width (words).
- `RD_WAIT`, 1, cycles the address is held with `mem_enable` high before `mem_D_Out` is sampled (≥1).

- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin transfer; sampled only in IDLE.
- `base_addr` in ADDR_W: first word address; captured on accepted `start`.
- `length` in LEN_W: word count; captured on accepted `start`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at transfer end.
- `mem_enable` out 1: memory enable.
- `mem_R_W` out 1: memory direction, 1 = read; never driven 0.
- `mem_Address` out ADDR_W: memory address.
- `mem_D_Out` in DATA_W: memory read data.
- `out_valid` out 1: `out_data` holds a word.
- `out_ready` in 1: consumer accepts when high with `out_valid`.
- `out_data` out DATA_W: read word.
- `out_last` out 1: qualifies the final word of the transfer.
- `checksum` out DATA_W: see Configuration.

## Operation
- FSM states:
  - IDLE: `start`=1 → capture base/length, `busy`=1. If length=0 go to DONE, else go to ADDR.
  - ADDR: `mem_enable`=1, `mem_Address`=current address, wait counter runs. After RD_WAIT cycles, capture `mem_D_Out` into `out_data`, set `out_valid`, set `out_last` if remaining=1, then go to OUT.
  - OUT: `mem_enable`=0; `out_data` and `out_last` are held stable. On `out_valid & out_ready`:
    - remaining=1 → DONE.
    - otherwise address+1 and remaining−1 → ADDR.
  - DONE: `done`=1 for one cycle, `busy`=0 next, go to IDLE.
- Address increment is modulo 2^ADDR_W: 0xFFFF wraps to 0x0000.
- `start` outside IDLE is ignored. `base_addr` and `length` changes after capture are ignored.
- `out_valid` is never dropped without a handshake. Each word is delivered exactly once, in address order.
- Reset values: `busy` 0, `done` 0, `mem_enable` 0, `mem_R_W` 1, `mem_Address` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `checksum` 0, FSM in IDLE.
- Reset asserted mid-transfer: all outputs take reset values immediately (asynchronous), no further memory access, transfer is abandoned. A new `start` after deassertion behaves normally.

## Timing
- `start` sampled at edge E0 → ADDR during cycle E0–E1, `mem_Address`=base.
- With RD_WAIT=1, data is captured at E1 and `out_valid` is high after E1.
- With `out_ready` tied high, throughput is one word per RD_WAIT+1 cycles. N words take N·(RD_WAIT+1) cycles from E0 to the last handshake.
- `done` is high in the cycle after the last handshake. `busy` falls with the edge ending `done`.
- Length 0: `done` is high the cycle after E0. `mem_enable` never asserts.

## Configuration
- `MEM_RD_CHECKSUM_EN` defined:
  - `checksum` is a running XOR of every handshaked word.
  - Cleared on accepted `start`.
  - Final value is stable from the `done` cycle until the next accepted `start`.
- `MEM_RD_CHECKSUM_EN` undefined: `checksum` is tied to 0 and no accumulator is built. The port list is unchanged.

## Test plan
- Preload addresses 0–7 with 0000AAAA, 000000AA, 000000BB, 000000CC, 000000DD, 000000EE, 000000FF, 0000FFFF. Start base=0, len=8, `out_ready`=1 → those 8 words in order, `out_last` only on 0000FFFF, last handshake 16 cycles after start, `done` one cycle later.
- Same transfer, `out_ready` low for 3 cycles while 000000BB is presented, plus a `start` pulse during the stall → `out_data` holds 000000BB, `mem_enable`=0 during the stall, no duplicate or skipped words, extra `start` ignored.
- len=0 → `done` pulses the cycle after start, `busy` high one cycle, `mem_enable` never 1, `out_valid` never 1.
- base=FFFE, len=4 → `mem_Address` sequence FFFE, FFFF, 0000, 0001.
- `reset_n` low after 3 words delivered → all outputs at reset values without a clock edge. A fresh start with base=0, len=2 after release returns 0000AAAA, 000000AA.
- With `MEM_RD_CHECKSUM_EN`, scenario 1 → `checksum`=00005544 at `done`. Without the macro, `checksum`=0 throughout.
